// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: pads a single-block message into sha256_core, starts it and streams the digest back
module sha256_msg_loader #(
  parameter logic [6:0] P_W_BASE      = 7'd0,
  parameter logic [6:0] P_STATUS_ADDR = 7'd96,
  parameter logic [6:0] P_DIGEST_BASE = 7'd64,
  parameter int         P_TIMEOUT     = 1023
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  input  logic [6:0] i_cmd_len,
  output logic       o_cmd_ready,
  input  logic       i_s_valid,
  input  logic [7:0] i_s_data,
  output logic       o_s_ready,
  output logic       o_d_valid,
  output logic [7:0] o_d_data,
  output logic       o_d_last,
  input  logic       i_d_ready,
  output logic       o_err,
  output logic       o_busy,
  output logic [6:0] o_core_addr,
  output logic [7:0] o_core_data,
  output logic       o_core_we,
  input  logic [7:0] i_core_rdata,
  input  logic       i_core_irq
);
  localparam int LP_TW = $clog2(P_TIMEOUT + 1);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_START, S_WAIT_LO, S_WAIT_HI, S_READ} state_t;
  state_t           r_state, w_next;
  logic [6:0]       r_k, r_len;
  logic [4:0]       r_j;
  logic [LP_TW-1:0] r_tmr;
  logic             r_d_valid, r_err;
  logic [7:0]       r_d_data;
  logic             w_err_set, w_s_xfer, w_d_xfer, w_tmo, w_wait;
  logic [9:0]       w_bits;
  logic [7:0]       w_pad;
  assign w_bits      = {r_len, 3'd0};
  assign w_pad       = r_k == r_len ? 8'h80 : r_k == 7'd62 ? {6'd0, w_bits[9:8]} : r_k == 7'd63 ? w_bits[7:0] : 8'h00;
  assign o_cmd_ready = r_state == S_IDLE;
  assign o_s_ready   = r_state == S_LOAD;
  assign o_busy      = r_state != S_IDLE;
  assign w_s_xfer    = i_s_valid && o_s_ready;
  assign w_d_xfer    = r_d_valid && i_d_ready;
  assign w_tmo       = r_tmr == LP_TW'(P_TIMEOUT - 1);
  assign w_wait      = r_state == S_WAIT_LO || r_state == S_WAIT_HI;
  assign o_d_valid   = r_d_valid;
  assign o_d_data    = r_d_data;
  assign o_d_last    = r_d_valid && r_j == 5'd31;
  assign o_err       = r_err;
  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  // Next state and core bus drive; the bus stays quiet while waiting so the core keeps running
  always_comb begin
    w_next      = r_state;
    w_err_set   = 1'b0;
    o_core_we   = 1'b0;
    o_core_addr = 7'd0;
    o_core_data = 8'd0;
    case (r_state)
      S_IDLE:
        if (i_cmd_valid) begin
          if (i_cmd_len > 7'd55) w_err_set = 1'b1;
          else w_next = i_cmd_len == 7'd0 ? S_PAD : S_LOAD;
        end
      S_LOAD: begin
        o_core_we   = w_s_xfer;
        o_core_addr = w_s_xfer ? P_W_BASE + 7'd63 - r_k : 7'd0;
        o_core_data = w_s_xfer ? i_s_data : 8'd0;
        if (w_s_xfer && r_k == r_len - 7'd1) w_next = S_PAD;
      end
      S_PAD: begin
        o_core_we   = 1'b1;
        o_core_addr = P_W_BASE + 7'd63 - r_k;
        o_core_data = w_pad;
        if (r_k == 7'd63) w_next = S_START;
      end
      S_START: begin
        o_core_we   = 1'b1;
        o_core_addr = P_STATUS_ADDR;
        o_core_data = 8'h01;
        w_next      = S_WAIT_LO;
      end
      S_WAIT_LO:
        if (!i_core_irq) w_next = S_WAIT_HI;
        else if (w_tmo) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end
      S_WAIT_HI:
        if (i_core_irq) w_next = S_READ;
        else if (w_tmo) begin
          w_err_set = 1'b1;
          w_next    = S_IDLE;
        end
      S_READ: begin
        o_core_addr = P_DIGEST_BASE + 7'd31 - {2'd0, r_j};
        if (w_d_xfer && r_j == 5'd31) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
  // Byte counters, wait timer, latched length, digest output register and error pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k       <= 7'd0;
      r_len     <= 7'd0;
      r_j       <= 5'd0;
      r_tmr     <= '0;
      r_err     <= 1'b0;
      r_d_valid <= 1'b0;
      r_d_data  <= 8'd0;
    end else begin
      r_err     <= w_err_set;
      r_len     <= o_cmd_ready && i_cmd_valid ? i_cmd_len : r_len;
      r_k       <= r_state == S_IDLE ? 7'd0 : (w_s_xfer || r_state == S_PAD) ? r_k + 7'd1 : r_k;
      r_tmr     <= w_wait && w_next == r_state ? r_tmr + LP_TW'(1) : '0;
      r_j       <= r_state == S_IDLE ? 5'd0 : (r_state == S_READ && w_d_xfer) ? r_j + 5'd1 : r_j;
      r_d_valid <= r_state == S_READ && !w_d_xfer;
      r_d_data  <= r_state == S_READ && !r_d_valid ? i_core_rdata : r_d_data;
    end
  end
endmodule
